// File: rtl/ahb_apb_pkg.sv
// Shared types for the APB side of the AHB-to-APB bridge.
// The request struct is sized by the package width constants; the
// controller supports ADDR_W/DATA_W up to those widths.
package ahb_apb_pkg;

  localparam int PKG_ADDR_W = 32;
  localparam int PKG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] wdata;
    logic                  write;
  } apb_req_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bus bundle between the AHB front end, the APB master controller and
// the APB peripherals. PSLVERR/HRESP exist only when APB_PSLVERR_EN is
// defined.
interface apb_master_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic              VALID;
  logic [ADDR_W-1:0] HADDR_TEMP;
  logic [DATA_W-1:0] HWDATA_TEMP;
  logic              HWRITE_TEMP;
  logic              HREADYOUT;
  logic [DATA_W-1:0] HRDATA;
  logic              XFER_DONE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic [NUM_SLV-1:0] PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
`ifdef APB_PSLVERR_EN
  logic              PSLVERR;
  logic              HRESP;
`endif

  // Controller view
  modport master (
`ifdef APB_PSLVERR_EN
    input  PSLVERR,
    output HRESP,
`endif
    input  VALID, HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP, PRDATA, PREADY,
    output HREADYOUT, HRDATA, XFER_DONE, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  // Environment view (front end plus peripherals)
  modport slave (
`ifdef APB_PSLVERR_EN
    output PSLVERR,
    input  HRESP,
`endif
    output VALID, HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP, PRDATA, PREADY,
    input  HREADYOUT, HRDATA, XFER_DONE, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

endinterface

// File: rtl/apb_req_fifo.sv
// Request FIFO for the APB master. Exposes the head and the entry behind
// it so the controller can chain transfers without an idle cycle.
module apb_req_fifo
  import ahb_apb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  apb_req_t         wr_req,
  output apb_req_t         head,
  output apb_req_t         head_next,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  apb_req_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_nxt;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state, cleared on reset (stored entries become unreachable)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_req;
  end

  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign head       = mem[rd_ptr_q];
  assign head_next  = mem[rd_ptr_nxt];
  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer of the AHB-to-APB bridge: buffers front-end
// requests, runs SETUP/ACCESS phases, decodes the peripheral select and
// returns read data and completion. Optional macro: APB_PSLVERR_EN adds
// PSLVERR sampling and the HRESP error flag.
module apb_master_ctrl
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W     = PKG_ADDR_W,
  parameter int DATA_W     = PKG_DATA_W,
  parameter int NUM_SLV    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int SEL_LSB    = 12
) (
  input  logic             HCLK,
  input  logic             HRESET,
  apb_master_ctrl_if.master bus
);

  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              xfer_done_q, xfer_done_d;
`ifdef APB_PSLVERR_EN
  logic              hresp_q, hresp_d;
`endif

  apb_req_t          push_req, fifo_head, fifo_head_next, load_req;
  logic              fifo_full, fifo_empty, push, done, load;
  logic [CNT_W-1:0]  fifo_count;
  logic [SEL_W-1:0]  sel_idx;

  assign push     = bus.VALID && !fifo_full;
  assign done     = (state_q == ACCESS) && bus.PREADY;
  assign push_req = '{addr:  PKG_ADDR_W'(bus.HADDR_TEMP),
                      wdata: PKG_DATA_W'(bus.HWDATA_TEMP),
                      write: bus.HWRITE_TEMP};

  apb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (HCLK),
    .rst       (HRESET),
    .push      (push),
    .pop       (done),
    .wr_req    (push_req),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next state and transfer-register load; when the popped head was the
  // only entry but a push lands on the same edge, the pushed request is
  // forwarded so the next SETUP follows without an idle cycle
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_req = fifo_head;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          if (fifo_count > CNT_W'(1)) begin
            state_d  = SETUP;
            load     = 1'b1;
            load_req = fifo_head_next;
          end else if (push) begin
            state_d  = SETUP;
            load     = 1'b1;
            load_req = push_req;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer registers and completion response
  always_comb begin
    paddr_d     = load ? ADDR_W'(load_req.addr)  : paddr_q;
    pwdata_d    = load ? DATA_W'(load_req.wdata) : pwdata_q;
    pwrite_d    = load ? load_req.write          : pwrite_q;
    hrdata_d    = (done && !pwrite_q) ? bus.PRDATA : hrdata_q;
    xfer_done_d = done;
`ifdef APB_PSLVERR_EN
    hresp_d     = done && bus.PSLVERR;
`endif
  end

  // FSM state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // APB address/data and response registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      hrdata_q    <= '0;
      xfer_done_q <= 1'b0;
`ifdef APB_PSLVERR_EN
      hresp_q     <= 1'b0;
`endif
    end else begin
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      hrdata_q    <= hrdata_d;
      xfer_done_q <= xfer_done_d;
`ifdef APB_PSLVERR_EN
      hresp_q     <= hresp_d;
`endif
    end
  end

  assign sel_idx       = paddr_q[SEL_LSB +: SEL_W];
  assign bus.PSEL      = (state_q != IDLE) ? (NUM_SLV'(1) << sel_idx) : '0;
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.XFER_DONE = xfer_done_q;
  assign bus.HREADYOUT = !fifo_full;
`ifdef APB_PSLVERR_EN
  assign bus.HRESP     = hresp_q;
`endif

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl: table-driven directed vectors, hand
// sequences for multi-cycle corners, and randomized traffic checked
// against a transaction-level reference model. Honors APB_PSLVERR_EN.
module tb_apb_master_ctrl;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int NS      = 4;
  localparam int DEPTH   = 2;
  localparam int SEL_LSB = 12;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  logic err_in = 1'b0;

  apb_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

  apb_master_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .FIFO_DEPTH(DEPTH), .SEL_LSB(SEL_LSB)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

`ifdef APB_PSLVERR_EN
  assign bus.PSLVERR = err_in;
`endif

  always #5 HCLK = ~HCLK;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } req_s;

  req_s        mq[$];      // requests held by the controller, head in flight
  req_s        cur;        // transfer currently (or last) on the bus
  bit          busy;
  int          age;        // cycles since the transfer's SETUP began
  logic        e_done, e_hresp;
  logic [31:0] e_hrdata;
  logic [31:0] order_q[$];

  function automatic void model_reset();
    mq.delete();
    cur      = '{addr: 32'h0, wdata: 32'h0, write: 1'b0};
    busy     = 1'b0;
    age      = 0;
    e_done   = 1'b0;
    e_hresp  = 1'b0;
    e_hrdata = 32'h0;
  endfunction

  function automatic void model_step();
    bit   fin      = busy && (age >= 1) && (bus.PREADY === 1'b1);
    int   pre_size = mq.size();
    bit   acc      = (bus.VALID === 1'b1) && (pre_size < DEPTH);
    req_s r;
    e_done  = fin;
    e_hresp = fin && err_in;
    if (fin) begin
      if (!cur.write) e_hrdata = bus.PRDATA;
      void'(mq.pop_front());
    end
    if (acc) begin
      r.addr  = bus.HADDR_TEMP;
      r.wdata = bus.HWDATA_TEMP;
      r.write = bus.HWRITE_TEMP;
      mq.push_back(r);
    end
    if (fin) begin
      if (mq.size() > 0) begin cur = mq[0]; age = 0; end
      else busy = 1'b0;
    end else if (busy) begin
      age++;
    end else if (pre_size > 0) begin
      busy = 1'b1; age = 0; cur = mq[0];
    end
  endfunction

  function automatic logic [31:0] exp_psel();
    if (!busy) return 32'h0;
    return 32'h1 << ((cur.addr >> SEL_LSB) % NS);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("PSEL",      32'(bus.PSEL),      exp_psel());
    cmp("PENABLE",   32'(bus.PENABLE),   32'(busy && age >= 1));
    cmp("PADDR",     bus.PADDR,          cur.addr);
    cmp("PWDATA",    bus.PWDATA,         cur.wdata);
    cmp("PWRITE",    32'(bus.PWRITE),    32'(cur.write));
    cmp("HREADYOUT", 32'(bus.HREADYOUT), 32'(mq.size() < DEPTH));
    cmp("XFER_DONE", 32'(bus.XFER_DONE), 32'(e_done));
    cmp("HRDATA",    bus.HRDATA,         e_hrdata);
`ifdef APB_PSLVERR_EN
    cmp("HRESP",     32'(bus.HRESP),     32'(e_hresp));
`endif
  endtask

  // One clock: record completing address, advance model at the edge,
  // then compare #1 later
  task automatic tick();
    if (bus.PENABLE === 1'b1 && bus.PREADY === 1'b1) order_q.push_back(bus.PADDR);
    @(posedge HCLK);
    if (HRESET) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic r, input logic [31:0] pd);
    bus.VALID       = v;
    bus.HWRITE_TEMP = w;
    bus.HADDR_TEMP  = a;
    bus.HWDATA_TEMP = d;
    bus.PREADY      = r;
    bus.PRDATA      = pd;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 1, 0);
    repeat (6) tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        valid, write;
    logic [31:0] addr, wdata;
    logic        pready;
    logic [31:0] prdata;
    logic [3:0]  e_psel;
    logic        e_pen, e_done, e_hready;
    logic [31:0] e_paddr, e_hrdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [3:0]  pen_seq;
    logic [15:0] psel_seq;
    bit          pend;
    bit          acc;

    tbl[0]  = '{1, 1, 32'h0000_2004, 32'hA5A5_0001, 1, 32'h0, 4'b0000, 0, 0, 1, 32'h0,         32'h0};
    tbl[1]  = '{0, 0, 32'h0,         32'h0,         1, 32'h0, 4'b0100, 0, 0, 1, 32'h0000_2004, 32'h0};
    tbl[2]  = '{0, 0, 32'h0,         32'h0,         1, 32'h0, 4'b0100, 1, 0, 1, 32'h0000_2004, 32'h0};
    tbl[3]  = '{0, 0, 32'h0,         32'h0,         1, 32'h0, 4'b0000, 0, 1, 1, 32'h0000_2004, 32'h0};
    tbl[4]  = '{1, 0, 32'h0000_1000, 32'h0,         0, 32'h0, 4'b0000, 0, 0, 1, 32'h0000_2004, 32'h0};
    tbl[5]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0, 4'b0010, 0, 0, 1, 32'h0000_1000, 32'h0};
    tbl[6]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0, 4'b0010, 1, 0, 1, 32'h0000_1000, 32'h0};
    tbl[7]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0, 4'b0010, 1, 0, 1, 32'h0000_1000, 32'h0};
    tbl[8]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0, 4'b0010, 1, 0, 1, 32'h0000_1000, 32'h0};
    tbl[9]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0, 4'b0010, 1, 0, 1, 32'h0000_1000, 32'h0};
    tbl[10] = '{0, 0, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 4'b0000, 0, 1, 1, 32'h0000_1000, 32'hDEAD_BEEF};
    tbl[11] = '{0, 0, 32'h0,         32'h0,         1, 32'h0, 4'b0000, 0, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF};

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    check_all();
    HRESET = 1'b0;

    // Single write zero-wait, then read with three wait states
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].valid, tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].pready, tbl[i].prdata);
      tick();
      cmp($sformatf("tbl%0d_psel", i),   32'(bus.PSEL),      32'(tbl[i].e_psel));
      cmp($sformatf("tbl%0d_pen", i),    32'(bus.PENABLE),   32'(tbl[i].e_pen));
      cmp($sformatf("tbl%0d_done", i),   32'(bus.XFER_DONE), 32'(tbl[i].e_done));
      cmp($sformatf("tbl%0d_hready", i), 32'(bus.HREADYOUT), 32'(tbl[i].e_hready));
      cmp($sformatf("tbl%0d_paddr", i),  bus.PADDR,          tbl[i].e_paddr);
      cmp($sformatf("tbl%0d_hrdata", i), bus.HRDATA,         tbl[i].e_hrdata);
    end
    drain();

    // FIFO full back-pressure and ordering
    order_q.delete();
    drive(1, 0, 32'h0000_3000, 32'h0, 0, 32'h1111_1111); tick();
    drive(1, 1, 32'h0040_1008, 32'hB0B0_0002, 0, 32'h0); tick();
    cmp("full_hready_after_2nd", 32'(bus.HREADYOUT), 32'h0);
    drive(1, 1, 32'h0000_2010, 32'hC0C0_0003, 0, 32'h0);
    repeat (4) begin
      tick();
      cmp("full_hready_held", 32'(bus.HREADYOUT), 32'h0);
    end
    bus.PREADY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      acc = (bus.VALID === 1'b1) && (mq.size() < DEPTH);
      tick();
      if (acc) bus.VALID = 1'b0;
    end
    cmp("order_count", 32'(order_q.size()), 32'd3);
    if (order_q.size() == 3) begin
      cmp("order_0", order_q[0], 32'h0000_3000);
      cmp("order_1", order_q[1], 32'h0040_1008);
      cmp("order_2", order_q[2], 32'h0000_2010);
    end
    drain();

    // Back-to-back writes: SETUP, ACCESS, SETUP, ACCESS
    drive(1, 1, 32'h0000_3000, 32'h0000_00A1, 1, 0); tick();
    drive(1, 1, 32'h0000_0004, 32'h0000_00A2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.VALID = 1'b0;
      pen_seq[3-i]          = bus.PENABLE;
      psel_seq[15-4*i -: 4] = bus.PSEL;
    end
    cmp("b2b_penable", 32'(pen_seq), 32'b0101);
    cmp("b2b_psel", 32'(psel_seq), 32'h8811);
    drain();

    // Reset mid-transfer with one entry queued
    drive(1, 0, 32'h0000_1000, 32'h0, 0, 32'h5555_AAAA); tick();
    drive(1, 1, 32'h0000_2000, 32'h7777_0000, 0, 32'h0); tick();
    bus.VALID = 1'b0;
    tick();
    cmp("rst_pre_access", 32'(bus.PENABLE), 32'h1);
    HRESET = 1'b1;
    #1;
    model_reset();
    cmp("rst_psel", 32'(bus.PSEL), 32'h0);
    cmp("rst_penable", 32'(bus.PENABLE), 32'h0);
    cmp("rst_hready", 32'(bus.HREADYOUT), 32'h1);
    bus.PREADY = 1'b1;
    tick();
    #2 HRESET = 1'b0;
    repeat (5) begin
      tick();
      cmp("rst_no_done", 32'(bus.XFER_DONE), 32'h0);
    end

`ifdef APB_PSLVERR_EN
    // Error completion, then a clean transfer
    drive(1, 1, 32'h0000_2000, 32'hE0E0_0001, 0, 0); tick();
    bus.VALID = 1'b0; tick();
    tick();
    bus.PREADY = 1'b1; err_in = 1'b1; tick();
    cmp("err_done", 32'(bus.XFER_DONE), 32'h1);
    cmp("err_hresp", 32'(bus.HRESP), 32'h1);
    err_in = 1'b0; tick();
    cmp("err_hresp_clear", 32'(bus.HRESP), 32'h0);
    drive(1, 1, 32'h0000_3000, 32'hE0E0_0002, 1, 0); tick();
    bus.VALID = 1'b0;
    repeat (3) tick();
    cmp("ok_done", 32'(bus.XFER_DONE), 32'h1);
    cmp("ok_hresp", 32'(bus.HRESP), 32'h0);
    drain();
`endif

    // Randomized traffic; upstream holds a request until accepted
    pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1'b1;
        drive(1, 1'($urandom_range(0, 1)), $urandom, $urandom, bus.PREADY, bus.PRDATA);
      end
      bus.VALID  = pend;
      bus.PREADY = ($urandom_range(0, 2) != 0);
      bus.PRDATA = $urandom;
      err_in     = 1'($urandom_range(0, 1));
      acc = pend && (mq.size() < DEPTH);
      tick();
      if (acc) pend = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Sequences the APB side of the AHB-to-APB bridge. It takes the transfers captured by the AHB slave front end (a `VALID` strobe with address, write data and direction) and buffers them in a small request FIFO. Each buffered transfer is then driven onto APB as a SETUP phase followed by an ACCESS phase, and the controller decodes which of `NUM_SLV` peripherals it goes to. It back-pressures the AHB front end with `HREADYOUT` and returns read data and completion status.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `NUM_SLV`, 4, number of APB peripherals; power of 2, between 2 and 16.
- `FIFO_DEPTH`, 2, request FIFO entries; power of 2, at least 2.
- `SEL_LSB`, 12, lowest address bit of the peripheral select field.

Ports (one clock; reset is asynchronous and active-high):
- `HCLK`, in, 1: clock; all state changes on the rising edge.
- `HRESET`, in, 1: asynchronous, active-high reset.
- `VALID`, in, 1: a request is present on this cycle.
- `HADDR_TEMP`, in, `ADDR_W`: request address.
- `HWDATA_TEMP`, in, `DATA_W`: request write data.
- `HWRITE_TEMP`, in, 1: 1 = write, 0 = read.
- `HREADYOUT`, out, 1: FIFO can accept a request this cycle.
- `HRDATA`, out, `DATA_W`: data from the last completed read.
- `XFER_DONE`, out, 1: one-cycle pulse when an APB transfer completes.
- `HRESP`, out, 1: error flag, valid while `XFER_DONE` is high (only with `APB_PSLVERR_EN`).
- `PADDR`, out, `ADDR_W`: APB address.
- `PWDATA`, out, `DATA_W`: APB write data.
- `PWRITE`, out, 1: APB direction.
- `PSEL`, out, `NUM_SLV`: one-hot peripheral select.
- `PENABLE`, out, 1: APB enable.
- `PRDATA`, in, `DATA_W`: APB read data.
- `PREADY`, in, 1: APB ready.
- `PSLVERR`, in, 1: APB slave error (only with `APB_PSLVERR_EN`).

## Operation
- **Push.** At a rising edge where `VALID` and `HREADYOUT` are both 1, {`HADDR_TEMP`, `HWDATA_TEMP`, `HWRITE_TEMP`} is written into the FIFO. `VALID` while `HREADYOUT` is 0 is ignored; upstream holds the request until it is accepted.
- **`HREADYOUT`** = !full, decoded from the registered FIFO count. There is no combinational path from any input to `HREADYOUT`.
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when the FIFO is non-empty.
  - SETUP -> ACCESS always, after one cycle.
  - ACCESS stays in ACCESS while `PREADY` is 0.
  - ACCESS with `PREADY` = 1 pops the FIFO head. Next state is SETUP if the FIFO still holds an entry after the pop, otherwise IDLE.
- **APB outputs.**
  - In SETUP and ACCESS, `PADDR`/`PWDATA`/`PWRITE` come from a registered copy of the FIFO head, loaded on IDLE->SETUP and on ACCESS->SETUP. They are stable for the whole transfer.
  - `PSEL` = one-hot of `PADDR[SEL_LSB +: log2(NUM_SLV)]`. Every address decodes to a peripheral; no decode error exists.
  - `PENABLE` is 1 only in ACCESS.
  - In IDLE, `PSEL` = 0 and `PENABLE` = 0, and `PADDR`/`PWDATA`/`PWRITE` hold their last values.
- **Completion** (ACCESS with `PREADY` = 1):
  - `XFER_DONE` pulses 1 on the next cycle.
  - For a read, `HRDATA` <= `PRDATA`. For a write, `HRDATA` holds.
- **Simultaneous push and pop:** both take effect and the count is unchanged. A push into a full FIFO cannot occur, because `HREADYOUT` is 0 when full.
- **Reset** (`HRESET` = 1) applies asynchronously, including mid-transfer; the in-flight transfer and all FIFO contents are discarded. Reset values:
  - state IDLE, FIFO count 0;
  - `HREADYOUT` = 1;
  - `PSEL` = 0, `PENABLE` = 0, `PADDR` = 0, `PWDATA` = 0, `PWRITE` = 0;
  - `HRDATA` = 0, `XFER_DONE` = 0, `HRESP` = 0.

## Timing
- Push at edge k -> SETUP (`PSEL` high) after edge k+1 -> ACCESS after edge k+2.
  - With `PREADY` = 1 in the first ACCESS cycle, completion is at edge k+3 and `XFER_DONE` is high after it.
- Back-to-back transfers with zero wait states take 2 cycles each. The FSM goes ACCESS -> SETUP with no IDLE cycle in between.
- Each cycle `PREADY` is low in ACCESS adds one cycle. All P* outputs are frozen during those cycles.
- FIFO count width = log2(`FIFO_DEPTH`)+1. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- `APB_PSLVERR_EN` defined:
  - `PSLVERR` input and `HRESP` output exist.
  - `PSLVERR` is sampled together with `PREADY` = 1 in ACCESS; `HRESP` carries that value during the `XFER_DONE` pulse and is 0 otherwise.
  - A read that completes with error still updates `HRDATA`.
- `APB_PSLVERR_EN` undefined:
  - neither port exists;
  - every completion is treated as OKAY.

## Structure
- Package `ahb_apb_pkg`:
  - `apb_state_t` enum (IDLE, SETUP, ACCESS);
  - `apb_req_t` struct {addr, wdata, write};
  - default width constants.
- Sub-module `apb_req_fifo`: parameterised synchronous FIFO of `apb_req_t`, with push, pop, head, full, empty and count, and asynchronous active-high reset.
- The FSM, select decode and response registers live in `apb_master_ctrl`.

## Test plan
- **Single write, zero wait:** reset, then `VALID` one cycle with addr 0x0000_2004, data 0xA5A5_0001, write 1. Expect:
  - `PSEL` = 0b0100 for 2 cycles, with `PENABLE` low then high;
  - `PADDR` 0x0000_2004, `PWDATA` 0xA5A5_0001;
  - `XFER_DONE` pulses once.
- **Read with wait states:** read of 0x0000_1000, `PREADY` held low 3 ACCESS cycles and `PRDATA` = 0xDEAD_BEEF. Expect:
  - 4 ACCESS cycles with P* stable;
  - `HRDATA` = 0xDEAD_BEEF on the cycle `XFER_DONE` is high.
- **FIFO full back-pressure:** 3 consecutive `VALID` cycles with `PREADY` low. Expect:
  - `HREADYOUT` falls after the second push;
  - the third request is accepted only after the first completes;
  - APB order is preserved.
- **Back-to-back:** 2 queued writes with `PREADY` = 1. Expect SETUP, ACCESS, SETUP, ACCESS on consecutive cycles, with no IDLE cycle between the transfers.
- **Reset mid-operation:** assert `HRESET` during ACCESS with 1 entry queued. Expect:
  - `PSEL`/`PENABLE` go to 0 immediately;
  - `HREADYOUT` = 1;
  - no `XFER_DONE` after reset is released.
- **Error (with `APB_PSLVERR_EN`):** write completing with `PSLVERR` = 1. Expect `HRESP` = 1 for exactly the `XFER_DONE` cycle, and 0 on the next transfer.
